adder_response_checker: RTL and testbench
=========================================

ADDER_RESPONSE_CHECKER -- requirements
Module: adder_response_checker

Interface
REQ-001 Parameter WIDTH, default 4, operand and sum width of the adder under observation.
REQ-002 Parameter MAX_WAIT, default 15, maximum settle cycles allowed before timeout (1..15).
REQ-003 Parameter CNT_W, default 8, width of the check and error counters.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 a  input  WIDTH  stimulus operand A, as driven to the adder.
REQ-007 b  input  WIDTH  stimulus operand B.
REQ-008 ci  input  1  stimulus carry-in.
REQ-009 sum  input  WIDTH  adder sum response.
REQ-010 co  input  1  adder carry-out response.
REQ-011 busy  output  1  high while a check is in progress (state WAIT).
REQ-012 done  output  1  one-cycle pulse when a check completes.
REQ-013 pass  output  1  result of the last completed check; 1 = response matched.
REQ-014 timeout  output  1  last completed check ended by timeout.
REQ-015 latency  output  4  settle cycles of the last passing check.
REQ-016 chk_cnt  output  CNT_W  number of completed checks, saturating.
REQ-017 err_cnt  output  CNT_W  number of failed checks, saturating.

Function
REQ-018 Stimulus vector S = {a,b,ci}; the block SHALL register S every cycle as S_q; a change is S != S_q at a rising edge.
REQ-019 Expected response E = a + b + ci computed at WIDTH+1 bits; compared against {co,sum}.
REQ-020 States: IDLE, WAIT; the state machine SHALL have no other reachable states.
REQ-021 IDLE: on change, go to WAIT with internal cycle counter lat = 0; otherwise stay in IDLE; done = 0.
REQ-022 WAIT, change detected: restart, lat = 0, stay in WAIT; no counter or result update (change has priority over match/timeout).
REQ-023 WAIT, no change, {co,sum} == E: go to IDLE; next cycle done = 1, pass = 1, timeout = 0, latency = lat, chk_cnt + 1.
REQ-024 WAIT, no change, mismatch, lat < MAX_WAIT: lat + 1, stay in WAIT.
REQ-025 WAIT, no change, mismatch, lat == MAX_WAIT: go to IDLE; next cycle done = 1, pass = 0, timeout = 1, latency unchanged, chk_cnt + 1, err_cnt + 1.
REQ-026 latency 0 means the response matched on the first WAIT cycle; maximum reported latency is MAX_WAIT.
REQ-027 pass, timeout, latency SHALL hold their values until the next completion or reset.
REQ-028 chk_cnt and err_cnt SHALL saturate at 2^CNT_W - 1 and never wrap.
REQ-029 busy SHALL equal (state == WAIT), registered.
REQ-030 Comparison uses only cycle-sampled values; glitches between edges SHALL have no effect.

Reset
REQ-031 With rst_n low at a rising edge: state = IDLE, lat = 0, S_q = 0, busy = 0, done = 0, pass = 0, timeout = 0, latency = 0, chk_cnt = 0, err_cnt = 0.
REQ-032 Reset SHALL abort an in-progress check with no completion report.
REQ-033 A nonzero S present when rst_n rises SHALL be detected as a change on the first active edge.

Verification
REQ-034 a=4'hA, b=4'h3, ci=0, sum=4'hD, co=0 already valid -> busy 1 cycle, done pulse, pass=1, latency=0, chk_cnt=1, err_cnt=0.
REQ-035 a=4'hF, b=4'h2, ci=1; response holds 0 for 3 WAIT cycles then sum=4'h2, co=1 -> pass=1, latency=3.
REQ-036 a=4'h2, b=4'h3, ci=0; sum stuck at 4'h0 -> done after MAX_WAIT+1=16 WAIT cycles, pass=0, timeout=1, err_cnt=1.
REQ-037 Change a from 4'hA to 4'h2 at WAIT cycle 2 with response pending -> lat restarts at 0, single completion, chk_cnt increments by 1 only.
REQ-038 rst_n low during WAIT -> no done pulse, all outputs 0 next cycle; CNT_W=2, 5 passing checks -> chk_cnt=3.

Source files
------------

// File: rtl/adder_response_checker.sv
// adder_response_checker: watches an adder's response to each stimulus change and reports
// pass/timeout, settle latency and saturating check/error counts.
module adder_response_checker #(
  parameter int WIDTH    = 4,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic [WIDTH-1:0] sum,
  input  logic             co,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [3:0]       latency,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t           state_q, state_d;
  logic [2*WIDTH:0] s_q;
  logic [3:0]       lat_q, lat_d, latency_q, latency_d;
  logic             done_q, done_d, pass_q, pass_d, timeout_q, timeout_d;
  logic [CNT_W-1:0] chk_q, chk_d, err_q, err_d;
  logic [WIDTH:0]   exp_v;
  logic             change, match, fin_ok, fin_to;
  assign exp_v  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
  assign change = {a, b, ci} != s_q;
  assign match  = {co, sum} == exp_v;
  // a stimulus change always restarts the settle count, ahead of match or timeout
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    fin_ok  = 1'b0;
    fin_to  = 1'b0;
    if (state_q == IDLE) begin
      if (change) begin
        state_d = WAIT;
        lat_d   = '0;
      end
    end else if (change) begin
      lat_d = '0;
    end else if (match) begin
      state_d = IDLE;
      fin_ok  = 1'b1;
    end else if (lat_q == 4'(MAX_WAIT)) begin
      state_d = IDLE;
      fin_to  = 1'b1;
    end else begin
      lat_d = lat_q + 4'd1;
    end
    done_d    = fin_ok | fin_to;
    pass_d    = done_d ? fin_ok : pass_q;
    timeout_d = done_d ? fin_to : timeout_q;
    latency_d = fin_ok ? lat_q : latency_q;
    chk_d     = (done_d && !(&chk_q)) ? chk_q + CNT_W'(1) : chk_q;
    err_d     = (fin_to && !(&err_q)) ? err_q + CNT_W'(1) : err_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      s_q       <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      latency_q <= '0;
      chk_q     <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      s_q       <= {a, b, ci};
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      latency_q <= latency_d;
      chk_q     <= chk_d;
      err_q     <= err_d;
    end
  end
  assign busy    = state_q == WAIT;
  assign done    = done_q;
  assign pass    = pass_q;
  assign timeout = timeout_q;
  assign latency = latency_q;
  assign chk_cnt = chk_q;
  assign err_cnt = err_q;
endmodule

// File: tb/tb_adder_response_checker.sv
// tb_adder_response_checker: scoreboard bench; expected completions are queued when stimulus is driven.
module tb_adder_response_checker;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] a = '0, b = '0, sum = '0;
  logic       ci = 1'b0, co = 1'b0;
  logic       busy, done, pass, timeout;
  logic [3:0] latency, latency2;
  logic [7:0] chk_cnt, err_cnt;
  logic       busy2, done2, pass2, timeout2;
  logic [1:0] chk_cnt2, err_cnt2;

  typedef struct packed {logic p; logic t; logic [3:0] l;} exp_t;
  exp_t       sb[$];
  int         checks = 0, errors = 0, n_done = 0;
  logic [3:0] last_lat = '0;

  always #5 clk = ~clk;

  adder_response_checker dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .ci(ci), .sum(sum), .co(co),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .latency(latency),
    .chk_cnt(chk_cnt), .err_cnt(err_cnt)
  );

  adder_response_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .ci(ci), .sum(sum), .co(co),
    .busy(busy2), .done(done2), .pass(pass2), .timeout(timeout2), .latency(latency2),
    .chk_cnt(chk_cnt2), .err_cnt(err_cnt2)
  );

  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({pass, timeout, latency} !== {e.p, e.t, e.l}) begin
          errors++;
          $display("FAIL completion got pass=%b timeout=%b latency=%0d expected pass=%b timeout=%b latency=%0d",
                   pass, timeout, latency, e.p, e.t, e.l);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  task automatic drive(input logic [3:0] ta, input logic [3:0] tb_v, input logic tci,
                       input logic [3:0] ts, input logic tco);
    a = ta; b = tb_v; ci = tci; sum = ts; co = tco;
  endtask

  task automatic wait_done(input int target, input int max_cyc, output int cyc);
    cyc = 0;
    while (n_done < target && cyc < max_cyc) begin
      @(negedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({busy, done, pass, timeout, latency, chk_cnt, err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h expected 0", {busy, done, pass, timeout, latency, chk_cnt, err_cnt});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_immediate_pass;
    int base;
    @(negedge clk); #1;
    base = n_done;
    drive(4'hA, 4'h3, 1'b0, 4'hD, 1'b0);
    sb.push_back('{1'b1, 1'b0, 4'd0});
    last_lat = 4'd0;
    @(negedge clk); #1;
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL imm_busy got busy/done=%b expected 10", {busy, done});
    end
    @(negedge clk); #1;
    checks++;
    if (n_done !== base + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL imm_done got done_count=%0d busy=%b expected %0d 0", n_done - base, busy, 1);
    end
    checks++;
    if ({chk_cnt, err_cnt} !== {8'd1, 8'd0}) begin
      errors++;
      $display("FAIL imm_counts got chk=%0d err=%0d expected 1 0", chk_cnt, err_cnt);
    end
  endtask

  task automatic test_settle;
    int base, cyc;
    @(negedge clk); #1;
    base = n_done;
    drive(4'hF, 4'h2, 1'b1, 4'h0, 1'b0);
    sb.push_back('{1'b1, 1'b0, 4'd3});
    last_lat = 4'd3;
    repeat (4) begin
      @(negedge clk); #1;
    end
    checks++;
    if (busy !== 1'b1 || n_done !== base) begin
      errors++;
      $display("FAIL settle_pending got busy=%b done_count=%0d expected 1 0", busy, n_done - base);
    end
    sum = 4'h2; co = 1'b1;
    wait_done(base + 1, 5, cyc);
    checks++;
    if (n_done !== base + 1 || cyc !== 1) begin
      errors++;
      $display("FAIL settle_done got done_count=%0d cycles=%0d expected 1 1", n_done - base, cyc);
    end
    checks++;
    if (chk_cnt !== 8'd2) begin
      errors++;
      $display("FAIL settle_chk got %0d expected 2", chk_cnt);
    end
  endtask

  task automatic test_timeout;
    int base, cyc;
    @(negedge clk); #1;
    base = n_done;
    drive(4'h2, 4'h3, 1'b0, 4'h0, 1'b0);
    sb.push_back('{1'b0, 1'b1, last_lat});
    wait_done(base + 1, 25, cyc);
    checks++;
    if (n_done !== base + 1 || cyc !== 17) begin
      errors++;
      $display("FAIL timeout_cycles got done_count=%0d cycles=%0d expected 1 17", n_done - base, cyc);
    end
    checks++;
    if ({chk_cnt, err_cnt} !== {8'd3, 8'd1}) begin
      errors++;
      $display("FAIL timeout_counts got chk=%0d err=%0d expected 3 1", chk_cnt, err_cnt);
    end
  endtask

  task automatic test_restart;
    int base, cyc;
    @(negedge clk); #1;
    base = n_done;
    drive(4'hA, 4'h3, 1'b0, 4'h0, 1'b0);
    sb.push_back('{1'b1, 1'b0, 4'd1});
    last_lat = 4'd1;
    repeat (2) begin
      @(negedge clk); #1;
    end
    a = 4'h2;
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b1 || n_done !== base) begin
      errors++;
      $display("FAIL restart_pending got busy=%b done_count=%0d expected 1 0", busy, n_done - base);
    end
    @(negedge clk); #1;
    sum = 4'h5;
    wait_done(base + 1, 5, cyc);
    checks++;
    if (n_done !== base + 1 || cyc !== 1) begin
      errors++;
      $display("FAIL restart_done got done_count=%0d cycles=%0d expected 1 1", n_done - base, cyc);
    end
    repeat (3) begin
      @(negedge clk); #1;
    end
    checks++;
    if (n_done !== base + 1 || {chk_cnt, err_cnt} !== {8'd4, 8'd1}) begin
      errors++;
      $display("FAIL restart_single got done_count=%0d chk=%0d err=%0d expected 1 4 1", n_done - base, chk_cnt, err_cnt);
    end
    checks++;
    if ({pass, timeout, latency} !== {1'b1, 1'b0, 4'd1}) begin
      errors++;
      $display("FAIL restart_hold got pass=%b timeout=%b latency=%0d expected 1 0 1", pass, timeout, latency);
    end
  endtask

  task automatic test_reset_abort;
    int base, cyc;
    @(negedge clk); #1;
    drive(4'h5, 4'h5, 1'b0, 4'h0, 1'b0);
    sb.push_back('{1'b0, 1'b1, last_lat});
    repeat (3) begin
      @(negedge clk); #1;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy got %b expected 1", busy);
    end
    rst_n = 1'b0;
    sb.delete();
    last_lat = 4'd0;
    base = n_done;
    drive(4'hA, 4'h3, 1'b0, 4'hD, 1'b0);
    @(negedge clk); #1;
    checks++;
    if ({busy, done, pass, timeout, latency, chk_cnt, err_cnt} !== '0 || n_done !== base) begin
      errors++;
      $display("FAIL abort_outputs got %h done_count=%0d expected 0 0", {busy, done, pass, timeout, latency, chk_cnt, err_cnt}, n_done - base);
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    sb.push_back('{1'b1, 1'b0, 4'd0});
    wait_done(base + 1, 5, cyc);
    checks++;
    if (n_done !== base + 1 || cyc !== 2 || chk_cnt !== 8'd1) begin
      errors++;
      $display("FAIL post_reset_change got done_count=%0d cycles=%0d chk=%0d expected 1 2 1", n_done - base, cyc, chk_cnt);
    end
  endtask

  task automatic test_saturation;
    int cyc;
    logic [4:0] s5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      s5 = 5'(i + 1) + 5'(i) + 5'(i % 2);
      drive(4'(i + 1), 4'(i), 1'(i % 2), s5[3:0], s5[4]);
      sb.push_back('{1'b1, 1'b0, 4'd0});
      wait_done(n_done + 1, 5, cyc);
      checks++;
      if (cyc !== 2) begin
        errors++;
        $display("FAIL sat_pass%0d got cycles=%0d expected 2", i, cyc);
      end
    end
    checks++;
    if ({chk_cnt2, chk_cnt} !== {2'd3, 8'd6}) begin
      errors++;
      $display("FAIL sat_chk got chk2=%0d chk=%0d expected 3 6", chk_cnt2, chk_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      drive(4'(i + 8), 4'h1, 1'b0, 4'(i + 10), 1'b0);
      sb.push_back('{1'b0, 1'b1, 4'd0});
      wait_done(n_done + 1, 25, cyc);
      checks++;
      if (cyc !== 17) begin
        errors++;
        $display("FAIL sat_to%0d got cycles=%0d expected 17", i, cyc);
      end
    end
    checks++;
    if ({chk_cnt2, err_cnt2, chk_cnt, err_cnt} !== {2'd3, 2'd3, 8'd10, 8'd4}) begin
      errors++;
      $display("FAIL sat_err got chk2=%0d err2=%0d chk=%0d err=%0d expected 3 3 10 4", chk_cnt2, err_cnt2, chk_cnt, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_immediate_pass();
    test_settle();
    test_timeout();
    test_restart();
    test_reset_abort();
    test_saturation();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
